// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan decoder:
// glyph encodings (active-low {g,f,e,d,c,b,a}), idle levels, FSM states
// and the anode-vector decode helper.
package sseg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // All segments off; also the idle level of the cathode synchronizers.
  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  // No digit selected: blanking gap between digit activations.
  localparam logic [3:0] ANODE_IDLE = 4'hF;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HELD   = 1'b1
  } state_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } anode_sel_t;

  // Maps a one-hot-low anode vector to its digit index; ok=0 otherwise.
  function automatic anode_sel_t anode_select(input logic [3:0] an);
    anode_sel_t s;
    s.ok  = 1'b1;
    s.idx = 2'd0;
    case (an)
      4'b1110: s.idx = 2'd0;
      4'b1101: s.idx = 2'd1;
      4'b1011: s.idx = 2'd2;
      4'b0111: s.idx = 2'd3;
      default: s.ok  = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Scanned-display bus: the anode/cathode lines from the display driver side
// and the decoded frame/status returned by the decoder.
interface sseg_scan_decoder_if;
  logic [3:0] sseg_an;
  logic [6:0] sseg_ca;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       frame_valid;
  logic       err_pattern;
  logic       err_anode;
  logic       display_lost;

  // Display driver side: produces the scan lines, observes decoded results.
  modport master (
    output sseg_an, sseg_ca,
    input  digit0, digit1, digit2, digit3,
    input  frame_valid, err_pattern, err_anode, display_lost
  );

  // Decoder side: consumes the scan lines, produces decoded results.
  modport slave (
    input  sseg_an, sseg_ca,
    output digit0, digit1, digit2, digit3,
    output frame_valid, err_pattern, err_anode, display_lost
  );
endinterface

// File: rtl/sseg_glyph_decode.sv
// Combinational reverse lookup of an active-low seven-segment pattern to its
// hex value; hit_o is low for any pattern outside the 16-glyph table.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] ca_i,
  output logic       hit_o,
  output logic [3:0] value_o
);

  // Table match; blank and any partial pattern fall through to a miss.
  always_comb begin
    hit_o   = 1'b1;
    value_o = 4'h0;
    case (ca_i)
      GLYPH_0: value_o = 4'h0;
      GLYPH_1: value_o = 4'h1;
      GLYPH_2: value_o = 4'h2;
      GLYPH_3: value_o = 4'h3;
      GLYPH_4: value_o = 4'h4;
      GLYPH_5: value_o = 4'h5;
      GLYPH_6: value_o = 4'h6;
      GLYPH_7: value_o = 4'h7;
      GLYPH_8: value_o = 4'h8;
      GLYPH_9: value_o = 4'h9;
      GLYPH_A: value_o = 4'hA;
      GLYPH_B: value_o = 4'hB;
      GLYPH_C: value_o = 4'hC;
      GLYPH_D: value_o = 4'hD;
      GLYPH_E: value_o = 4'hE;
      GLYPH_F: value_o = 4'hF;
      default: hit_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed seven-segment display: synchronizes the scan
// lines, waits for each digit activation to settle, decodes it and publishes
// a complete 4-digit frame atomically. A watchdog flags a display that has
// stopped producing complete frames.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LOST_CYCLES   = 2**20
) (
  input logic           clk,
  input logic           rst,
  sseg_scan_decoder_if.slave scan
);

  localparam int unsigned STAB_W = 8;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam int unsigned WD_W = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOST_CYCLES - 1);

  logic [3:0]        an_s1_q, an_s2_q, an_smp_q;
  logic [6:0]        ca_s1_q, ca_s2_q, ca_smp_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  state_e            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0][3:0]   shadow_q, shadow_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic              frame_valid_q, frame_valid_d;
  logic              err_pattern_q, err_pattern_d;
  logic              err_anode_q, err_anode_d;
  logic              lost_q, lost_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              changed;
  logic              evaluate;
  logic              glyph_hit;
  logic [3:0]        glyph_value;
  logic [3:0]        mask_cap;
  anode_sel_t        sel;

  // The sample under evaluation is the one the stability counter has tracked.
  sseg_glyph_decode u_glyph (
    .ca_i    (ca_smp_q),
    .hit_o   (glyph_hit),
    .value_o (glyph_value)
  );

  assign sel      = anode_select(an_smp_q);
  assign changed  = {an_s2_q, ca_s2_q} != {an_smp_q, ca_smp_q};
  assign evaluate = (state_q == ST_SETTLE) && (stab_q == STAB_MAX);

  // Two-flop synchronizers plus the previous-sample register, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q  <= ANODE_IDLE;
      an_s2_q  <= ANODE_IDLE;
      an_smp_q <= ANODE_IDLE;
      ca_s1_q  <= SSEG_BLANK;
      ca_s2_q  <= SSEG_BLANK;
      ca_smp_q <= SSEG_BLANK;
    end else begin
      an_s1_q  <= scan.sseg_an;
      an_s2_q  <= an_s1_q;
      an_smp_q <= an_s2_q;
      ca_s1_q  <= scan.sseg_ca;
      ca_s2_q  <= ca_s1_q;
      ca_smp_q <= ca_s2_q;
    end
  end

  // Stability tracking, settle/hold FSM, capture, frame assembly, watchdog.
  always_comb begin
    stab_d        = stab_q;
    state_d       = state_q;
    mask_d        = mask_q;
    shadow_d      = shadow_q;
    digit_d       = digit_q;
    frame_valid_d = 1'b0;
    err_pattern_d = 1'b0;
    err_anode_d   = 1'b0;
    lost_d        = lost_q;
    wd_d          = wd_q;
    mask_cap      = mask_q;

    if (changed) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end

    if (changed) begin
      state_d = ST_SETTLE;
    end else if (evaluate) begin
      state_d = ST_HELD;
    end

    // A settled pattern is evaluated exactly once per activation.
    if (evaluate && (an_smp_q != ANODE_IDLE)) begin
      if (!sel.ok) begin
        err_anode_d = 1'b1;
      end else if (!glyph_hit) begin
        err_pattern_d = 1'b1;
      end else begin
        shadow_d[sel.idx] = glyph_value;
        mask_cap          = mask_q | (4'b0001 << sel.idx);
        if (mask_cap == 4'hF) begin
          digit_d       = shadow_d;
          frame_valid_d = 1'b1;
          mask_d        = 4'h0;
        end else begin
          mask_d = mask_cap;
        end
      end
    end

    // A completed frame always beats a simultaneous watchdog expiry.
    if (frame_valid_d) begin
      wd_d   = '0;
      lost_d = 1'b0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end else if (!lost_q) begin
      lost_d = 1'b1;
      mask_d = 4'h0;
    end
  end

  // Control and status state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q        <= '0;
      state_q       <= ST_SETTLE;
      mask_q        <= 4'h0;
      frame_valid_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
      lost_q        <= 1'b0;
      wd_q          <= '0;
    end else begin
      stab_q        <= stab_d;
      state_q       <= state_d;
      mask_q        <= mask_d;
      frame_valid_q <= frame_valid_d;
      err_pattern_q <= err_pattern_d;
      err_anode_q   <= err_anode_d;
      lost_q        <= lost_d;
      wd_q          <= wd_d;
    end
  end

  // Shadow and published digit registers; a reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      digit_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      digit_q  <= digit_d;
    end
  end

  assign scan.digit0       = digit_q[0];
  assign scan.digit1       = digit_q[1];
  assign scan.digit2       = digit_q[2];
  assign scan.digit3       = digit_q[3];
  assign scan.frame_valid  = frame_valid_q;
  assign scan.err_pattern  = err_pattern_q;
  assign scan.err_anode    = err_anode_q;
  assign scan.display_lost = lost_q;

endmodule
